// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and helpers for the matrix-multiply engine.
//   state_t          engine FSM state encoding
//   idx_width/k_width/acc_width   size helpers used by the parametrised modules
//   DEF_*            derived widths for the default 4x4, 8-bit configuration
//   fmt_result       saturate or truncate an accumulator value to the output width
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    function automatic int idx_width(input int n);
        return $clog2(n * n);
    endfunction

    function automatic int k_width(input int n);
        return $clog2(n);
    endfunction

    // Holds N products of two DATA_W-bit operands without overflow.
    function automatic int acc_width(input int data_w, input int n);
        return 2 * data_w + $clog2(n);
    endfunction

    localparam int DEF_N      = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = acc_width(DEF_DATA_W, DEF_N);
    localparam int DEF_IDX_W  = idx_width(DEF_N);
    localparam int DEF_K_W    = k_width(DEF_N);

    // Result is returned in the low out_w bits; callers cast to their width.
    function automatic logic [63:0] fmt_result(input logic [63:0] acc,
                                               input int          out_w,
                                               input logic        sat);
        logic [63:0] mask;
        mask = (out_w >= 64) ? '1 : ((64'd1 << out_w) - 64'd1);
        if (sat && ((acc & ~mask) != 64'd0))
            return mask;
        return acc & mask;
    endfunction

endpackage

// File: rtl/matmul_engine_mac_unit.sv
// mac_unit: one multiply-accumulate per enabled cycle plus result formatting.
//   clk, rst     clock, async active-low reset
//   clear        zero the accumulator (has priority over enable)
//   enable       acc <= acc + a*w
//   a, w         operands
//   result_next  formatted value of acc + a*w, i.e. what acc holds after this MAC
module mac_unit
    import matmul_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N      = 4,
    parameter int OUT_W  = 16,
    parameter bit SAT    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] w,
    output logic [OUT_W-1:0]  result_next
);

    localparam int ACC_W = acc_width(DATA_W, N);

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [2*DATA_W-1:0] product;

    assign product = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, w};
    assign acc_sum = acc + ACC_W'(product);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (enable)
            acc <= acc_sum;
    end

    // Formatting the post-MAC sum lets the top register port_O on the last MAC edge.
    assign result_next = OUT_W'(fmt_result(64'(acc_sum), OUT_W, SAT));

endmodule

// File: rtl/matmul_engine.sv
// matmul_engine: N x N unsigned C = A * W with serial loading and a valid/ready result stream.
//   clk, rst                     clock, async active-low reset
//   port_A/write_enable_A        feature element write (row-major, auto-increment)
//   port_W/write_enable_W        weight element write (row-major, auto-increment)
//   start                        begin computation when both buffers are full
//   busy, done                   engine committed / one-cycle completion pulse
//   port_O, o_valid, o_ready     result stream, row-major C[i][j]
//   load_err                     sticky: write while busy or rejected start
//
// state | meaning
// IDLE  | loading allowed, waiting for start
// MAC   | accumulating A[i][k]*W[k][j], k = 0..N-1
// OUT   | C[i][j] presented on port_O, waiting for o_ready
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16,
    parameter bit SAT    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] port_A,
    input  logic              write_enable_A,
    input  logic [DATA_W-1:0] port_W,
    input  logic              write_enable_W,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [OUT_W-1:0]  port_O,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              load_err
);

    localparam int NN    = N * N;
    localparam int IDX_W = idx_width(N);
    localparam int K_W   = k_width(N);
    localparam int CNT_W = IDX_W + 1;

    logic [DATA_W-1:0] a_mem [NN];
    logic [DATA_W-1:0] w_mem [NN];

    state_t           state;
    logic [K_W-1:0]   i, j, k;
    logic [IDX_W-1:0] a_ptr, w_ptr;
    logic [CNT_W-1:0] a_cnt, w_cnt;
    logic [IDX_W-1:0] a_idx, w_idx;
    logic [OUT_W-1:0] result_next;
    logic             full, start_ok, wr_a_ok, wr_w_ok, wr_err;

    assign full     = (a_cnt == CNT_W'(NN)) && (w_cnt == CNT_W'(NN));
    assign start_ok = (state == IDLE) && start && full;
    // A write on the accepting edge is dropped: the operands are already committed.
    assign wr_a_ok  = write_enable_A && (state == IDLE) && !start_ok;
    assign wr_w_ok  = write_enable_W && (state == IDLE) && !start_ok;
    assign wr_err   = (write_enable_A || write_enable_W) && ((state != IDLE) || start_ok);

    assign a_idx = IDX_W'(int'(i) * N + int'(k));
    assign w_idx = IDX_W'(int'(k) * N + int'(j));

    always_ff @(posedge clk) begin
        if (wr_a_ok)
            a_mem[a_ptr] <= port_A;
        if (wr_w_ok)
            w_mem[w_ptr] <= port_W;
    end

    mac_unit #(
        .DATA_W (DATA_W),
        .N      (N),
        .OUT_W  (OUT_W),
        .SAT    (SAT)
    ) u_mac (
        .clk         (clk),
        .rst         (rst),
        .clear       (state != MAC),
        .enable      (state == MAC),
        .a           (a_mem[a_idx]),
        .w           (w_mem[w_idx]),
        .result_next (result_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            a_ptr    <= '0;
            w_ptr    <= '0;
            a_cnt    <= '0;
            w_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            o_valid  <= 1'b0;
            port_O   <= '0;
            load_err <= 1'b0;
        end else begin
            done <= 1'b0;

            if (wr_a_ok) begin
                a_ptr <= (a_ptr == IDX_W'(NN - 1)) ? '0 : a_ptr + 1'b1;
                if (a_cnt != CNT_W'(NN))
                    a_cnt <= a_cnt + 1'b1;
            end
            if (wr_w_ok) begin
                w_ptr <= (w_ptr == IDX_W'(NN - 1)) ? '0 : w_ptr + 1'b1;
                if (w_cnt != CNT_W'(NN))
                    w_cnt <= w_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (full) begin
                            state    <= MAC;
                            busy     <= 1'b1;
                            load_err <= 1'b0;
                            i        <= '0;
                            j        <= '0;
                            k        <= '0;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                end
                MAC: begin
                    if (k == K_W'(N - 1)) begin
                        state   <= OUT;
                        o_valid <= 1'b1;
                        port_O  <= result_next;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                OUT: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        k       <= '0;
                        if (j == K_W'(N - 1)) begin
                            j <= '0;
                            if (i == K_W'(N - 1)) begin
                                i     <= '0;
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                a_cnt <= '0;
                                w_cnt <= '0;
                                a_ptr <= '0;
                                w_ptr <= '0;
                            end else begin
                                i     <= i + 1'b1;
                                state <= MAC;
                            end
                        end else begin
                            j     <= j + 1'b1;
                            state <= MAC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed after the FSM so an error on the accepting edge survives the clear.
            if (wr_err)
                load_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_matmul_engine.sv
module tb_matmul_engine;
    localparam int N  = 4;
    localparam int NN = N * N;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] port_A = '0, port_W = '0;
    logic       write_enable_A = 1'b0, write_enable_W = 1'b0;
    logic       start = 1'b0, o_ready = 1'b1;

    logic        busy, done, o_valid, load_err;
    logic [15:0] port_O;
    logic        busy_s, done_s, o_valid_s, load_err_s;
    logic [7:0]  port_O_s;
    logic        busy_t, done_t, o_valid_t, load_err_t;
    logic [7:0]  port_O_t;

    matmul_engine #(.N(N), .DATA_W(8), .OUT_W(16), .SAT(1'b1)) dut (
        .clk(clk), .rst(rst), .port_A(port_A), .write_enable_A(write_enable_A),
        .port_W(port_W), .write_enable_W(write_enable_W), .start(start),
        .busy(busy), .done(done), .port_O(port_O), .o_valid(o_valid),
        .o_ready(o_ready), .load_err(load_err));

    matmul_engine #(.N(N), .DATA_W(8), .OUT_W(8), .SAT(1'b1)) dut_s (
        .clk(clk), .rst(rst), .port_A(port_A), .write_enable_A(write_enable_A),
        .port_W(port_W), .write_enable_W(write_enable_W), .start(start),
        .busy(busy_s), .done(done_s), .port_O(port_O_s), .o_valid(o_valid_s),
        .o_ready(o_ready), .load_err(load_err_s));

    matmul_engine #(.N(N), .DATA_W(8), .OUT_W(8), .SAT(1'b0)) dut_t (
        .clk(clk), .rst(rst), .port_A(port_A), .write_enable_A(write_enable_A),
        .port_W(port_W), .write_enable_W(write_enable_W), .start(start),
        .busy(busy_t), .done(done_t), .port_O(port_O_t), .o_valid(o_valid_t),
        .o_ready(o_ready), .load_err(load_err_t));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Bench model: buffers, load bookkeeping and the queue of results still owed.
    int unsigned a_ref [NN];
    int unsigned w_ref [NN];
    int          a_ptr_m = 0, w_ptr_m = 0, a_cnt_m = 0, w_cnt_m = 0;
    bit          busy_m = 0;
    int unsigned exp_q [$];
    int unsigned got_q [$];
    int unsigned a_src [NN];
    int unsigned w_src [NN];

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input bit ea, input int unsigned va, input bit ew, input int unsigned vw);
        if (ea) begin
            a_ref[a_ptr_m] = va & 8'hFF;
            a_ptr_m = (a_ptr_m + 1) % NN;
            if (a_cnt_m < NN) a_cnt_m++;
        end
        if (ew) begin
            w_ref[w_ptr_m] = vw & 8'hFF;
            w_ptr_m = (w_ptr_m + 1) % NN;
            if (w_cnt_m < NN) w_cnt_m++;
        end
    endtask

    task automatic write_both(input bit ea, input int unsigned va, input bit ew, input int unsigned vw);
        port_A = 8'(va);
        port_W = 8'(vw);
        write_enable_A = ea;
        write_enable_W = ew;
        tick();
        write_enable_A = 1'b0;
        write_enable_W = 1'b0;
        if (!busy_m) model_write(ea, va, ew, vw);
    endtask

    task automatic load_src();
        for (int e = 0; e < NN; e++) write_both(1'b1, a_src[e], 1'b1, w_src[e]);
    endtask

    task automatic push_expected();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                longint unsigned s = 0;
                for (int q = 0; q < N; q++) s += a_ref[r*N+q] * w_ref[q*N+c];
                exp_q.push_back(s > 65535 ? 65535 : int'(s));
            end
    endtask

    // Pulses start; the model decides acceptance and the DUT's busy must agree.
    task automatic do_start(input bit with_write_a, input int unsigned va);
        bit acc;
        acc = !busy_m && a_cnt_m == NN && w_cnt_m == NN;
        start = 1'b1;
        port_A = 8'(va);
        write_enable_A = with_write_a;
        tick();
        start = 1'b0;
        write_enable_A = 1'b0;
        if (acc) begin
            busy_m = 1;
            push_expected();
            a_cnt_m = 0; w_cnt_m = 0; a_ptr_m = 0; w_ptr_m = 0;
        end else if (!busy_m && with_write_a) begin
            model_write(1'b1, va, 1'b0, 0);
        end
        check("start_busy", busy, acc);
        if (!busy_m || acc) check("start_load_err", load_err, !acc || with_write_a);
    endtask

    task automatic wait_done(input int max_cyc, input bit rand_ready, input bit sat_chk, output int cyc);
        int seen_s;
        seen_s = 0;
        cyc = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            if (rand_ready) o_ready = 1'($urandom_range(0, 1));
            tick();
            if (sat_chk && o_valid_s && o_ready) begin
                check("sat_on", port_O_s, 255);
                check("sat_off", port_O_t, 4);
                seen_s++;
            end
            if (done) begin
                cyc = c;
                break;
            end
        end
        o_ready = 1'b1;
        if (cyc < 0) begin
            check("done_timeout", 0, 1);
        end else begin
            busy_m = 0;
            check("busy_after_done", busy, 0);
            check("results_outstanding", exp_q.size(), 0);
            tick();
            check("done_width", done, 0);
        end
        if (sat_chk) check("sat_count", seen_s, NN);
    endtask

    // Compare process: every handshake must deliver the next owed result; stalls must hold.
    bit          stall_hold = 0;
    logic [15:0] held = '0;
    always @(negedge clk) begin
        if (!rst) begin
            stall_hold = 0;
        end else begin
            if (stall_hold) check("stall_hold", {o_valid, port_O}, {1'b1, held});
            if (o_valid && o_ready) begin
                got_q.push_back(port_O);
                if (exp_q.size() == 0) check("unexpected_output", exp_q.size(), 1);
                else check("result", port_O, exp_q.pop_front());
            end
            stall_hold = o_valid && !o_ready;
            held = port_O;
        end
    end

    int unsigned w_rows [NN] = '{4,0,2,1, 4,3,2,0, 4,3,0,1, 4,3,2,1};
    int unsigned row_lit [N] = '{40, 27, 14, 8};

    initial begin
        int cyc;

        // Reset
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_o_valid", o_valid, 0);
        check("rst_port_O", port_O, 0);
        check("rst_load_err", load_err, 0);
        rst = 1'b1;
        tick();

        // Basic compute, o_ready held high
        for (int e = 0; e < NN; e++) begin
            a_src[e] = (e % N) + 1;
            w_src[e] = w_rows[e];
        end
        load_src();
        got_q.delete();
        do_start(1'b0, 0);
        wait_done(200, 1'b0, 1'b0, cyc);
        check("done_cycle", cyc, 80);
        check("basic_count", got_q.size(), NN);
        for (int t = 0; t < NN && t < got_q.size(); t++) check("basic_literal", got_q[t], row_lit[t % N]);

        // Backpressure
        load_src();
        got_q.delete();
        do_start(1'b0, 0);
        wait_done(3000, 1'b1, 1'b0, cyc);
        check("bp_count", got_q.size(), NN);
        for (int t = 0; t < NN && t < got_q.size(); t++) check("bp_literal", got_q[t], row_lit[t % N]);

        // Saturation: all operands 255
        for (int e = 0; e < NN; e++) begin
            a_src[e] = 255;
            w_src[e] = 255;
        end
        load_src();
        do_start(1'b0, 0);
        wait_done(200, 1'b0, 1'b1, cyc);

        // Load errors
        for (int e = 0; e < NN; e++) begin
            a_src[e] = (e * 5 + 1) % 11;
            w_src[e] = (e * 3 + 2) % 13;
        end
        for (int e = 0; e < NN; e++) write_both(e < NN - 1, a_src[e], 1'b1, w_src[e]);
        do_start(1'b0, 0);
        check("short_start_busy", busy, 0);
        check("short_start_err", load_err, 1);
        write_both(1'b1, a_src[NN-1], 1'b0, 0);
        check("err_sticky", load_err, 1);
        do_start(1'b0, 0);
        check("accept_clears_err", load_err, 0);
        write_both(1'b1, 99, 1'b1, 99);
        check("busy_write_err", load_err, 1);
        wait_done(200, 1'b0, 1'b0, cyc);
        load_src();
        do_start(1'b1, 77);
        check("start_edge_write_err", load_err, 1);
        wait_done(200, 1'b0, 1'b0, cyc);
        load_src();
        do_start(1'b0, 0);
        check("next_start_clears", load_err, 0);
        wait_done(200, 1'b0, 1'b0, cyc);

        // Wrap: 18 A writes, elements 0 and 1 take the last two
        for (int e = 0; e < NN + 2; e++)
            write_both(1'b1, (e * 7 + 3) & 8'hFF, e < NN, (e * 11 + 5) & 8'hFF);
        do_start(1'b0, 0);
        wait_done(200, 1'b0, 1'b0, cyc);
        do_start(1'b0, 0);
        check("no_reload_busy", busy, 0);
        check("no_reload_err", load_err, 1);

        // Reset mid-OUT
        for (int e = 0; e < NN; e++) begin
            a_src[e] = (e % N) + 1;
            w_src[e] = w_rows[e];
        end
        load_src();
        o_ready = 1'b0;
        do_start(1'b0, 0);
        cyc = -1;
        for (int c = 0; c < 20; c++) begin
            if (o_valid) begin
                cyc = c;
                break;
            end
            tick();
        end
        check("reach_out", cyc >= 0, 1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_o_valid", o_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        exp_q.delete();
        busy_m = 0;
        a_cnt_m = 0; w_cnt_m = 0; a_ptr_m = 0; w_ptr_m = 0;
        tick();
        rst = 1'b1;
        o_ready = 1'b1;
        tick();
        do_start(1'b0, 0);
        check("rst_needs_reload", busy, 0);
        load_src();
        got_q.delete();
        do_start(1'b0, 0);
        wait_done(200, 1'b0, 1'b0, cyc);
        for (int t = 0; t < NN && t < got_q.size(); t++) check("post_rst_literal", got_q[t], row_lit[t % N]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/matmul_engine.md
# matmul_engine

Parametrised N×N unsigned matrix-multiply engine with byte-serial operand loading and a flow-controlled result stream. Feature matrix A and weight matrix W are written element-by-element into internal row-major buffers. A start pulse computes C = A·W with one multiply-accumulate per cycle. Each C element is streamed out on a valid/ready port in row-major order. It is the generalised successor of the fixed 4×4, 8-bit, two-clock memory loader: single clock, configurable size and width, backpressure, and saturation.

## Interface
Parameters:
- N, 4, matrix dimension (N ≥ 2)
- DATA_W, 8, operand element width (unsigned)
- OUT_W, 16, result element width
- SAT, 1, 1 = saturate result to OUT_W; 0 = truncate to low OUT_W bits

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous and active-low
- port_A  in  DATA_W  feature element data
- write_enable_A  in  1  write port_A into A buffer this cycle
- port_W  in  DATA_W  weight element data
- write_enable_W  in  1  write port_W into W buffer this cycle
- start  in  1  request computation (level sampled)
- busy  out  1  high from accepted start until final result handshake
- done  out  1  one-cycle pulse after final result handshake
- port_O  out  OUT_W  result element C[i][j]
- o_valid  out  1  port_O holds a valid element
- o_ready  in  1  consumer accepts port_O
- load_err  out  1  sticky: write attempted while busy, or start rejected

## Operation
- Load (busy=0): each write_enable_A cycle stores port_A at a_ptr, a_ptr++. W is handled identically and independently. A and W may be written in the same cycle.
- Element k maps to row k/N, column k%N.
- a_cnt and w_cnt saturate at N². A pointer wraps to 0 after N²−1, and further writes overwrite from element 0 (count stays full).
- start in IDLE with a_cnt = w_cnt = N² is accepted. This clears load_err, sets busy, and zeroes the accumulator, i, j and k.
- start in IDLE with either count below N² is ignored and sets load_err. start while busy is ignored with no error.
- FSM states: IDLE, MAC, OUT.
  - IDLE → MAC on accepted start.
  - MAC: acc += A[i][k]·W[k][j] each cycle, k = 0..N−1. After the k = N−1 cycle, go to OUT.
  - OUT: o_valid=1, port_O = fmt(acc). On o_valid&&o_ready, advance j, then i (row-major). Go back to MAC with acc=0, k=0, or go to IDLE after element (N−1,N−1).
- Entering IDLE from OUT pulses done and clears a_cnt, w_cnt, a_ptr and w_ptr, so a reload is required.
- Writes while busy are dropped and set load_err.
- Internal accumulator width is ACC_W = 2·DATA_W + clog2(N), which never overflows.
- fmt: if SAT=1, acc ≥ 2^OUT_W yields all ones. Otherwise the result is acc[OUT_W−1:0].

## Timing
- Reset values: busy=0, done=0, o_valid=0, port_O=0, load_err=0, state=IDLE, all counts and pointers 0. Buffer contents are not reset.
- Reset is asynchronous at any point, including mid-MAC or mid-OUT: outputs drop immediately and a full reload is required.
- start sampled at edge E0. MAC accumulates at E1..EN, and o_valid is high after EN.
- With o_ready held high, each element takes N+1 cycles. A full matrix takes N²·(N+1) cycles after the start edge; for N=4 that is 80.
- port_O and o_valid are registered and stable while o_valid=1 && o_ready=0. o_ready has no combinational path to any output.
- busy falls and done rises at the same edge as the final handshake. done lasts 1 cycle.
- A write at the same edge as an accepted start is dropped and sets load_err. (busy is not yet visible, but the engine is committed.)

## Structure
- Package matmul_pkg holds:
  - the state enum (IDLE, MAC, OUT)
  - the clog2-based localparams: ACC_W, IDX_W = clog2(N²), K_W = clog2(N)
  - the fmt/saturation function
- Sub-module mac_unit holds the DATA_W×DATA_W multiplier, the ACC_W accumulator with clear/enable, and the SAT/truncate output formatting.
- Top level holds the buffers, the load counters, the FSM and the handshake.

## Test plan
- Basic compute (N=4): load W rows [4 0 2 1],[4 3 2 0],[4 3 0 1],[4 3 2 1] and A rows all [1 2 3 4], start, o_ready=1 → 16 outputs, each row 40 27 14 8. done appears at cycle 80 after start.
- Backpressure: same data, toggle o_ready pseudo-randomly → identical sequence, port_O held during stalls, no drops or duplicates.
- Saturation (OUT_W=8, all elements 255): SAT=1 → every output 255; SAT=0 → every output 4 (260100 mod 256).
- Load errors: start after 15 A writes → ignored, load_err=1, busy=0. Write during busy → data unchanged and load_err=1; the next accepted start clears it.
- Wrap and reload: write 18 A elements → elements 0,1 take the last two values. After done, start without reload is rejected.
- Reset mid-OUT: assert rst while o_valid=1 → o_valid, busy and done go to 0 immediately. Reload plus start gives a correct result.
